// File: rtl/pipelined_mem_interface_pkg.sv
// Shared types and helpers for the pipelined memory interface: report snapshot
// layout and the width helpers used to size counters and pointers.
package pipelined_mem_interface_pkg;

  typedef struct packed {
    logic [31:0] cycle;
    logic [7:0]  core;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] req_addr;
    logic [31:0] resp_addr;
    logic [7:0]  outstanding;
    logic [7:0]  fifo_level;
  } report_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Counters must reach the full depth, hence one bit more than the pointer.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipelined_mem_interface_if.sv
// Request/response bus between core load/store logic (master) and the
// pipelined memory interface (slave).
interface pipelined_mem_interface_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_write;
  logic [ADDRESS_BITS-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]     req_data;
  logic [DATA_WIDTH/8-1:0]   req_byte_en;
  logic                      resp_valid;
  logic                      resp_ready;
  logic [DATA_WIDTH-1:0]     resp_data;
  logic [ADDRESS_BITS-1:0]   resp_addr;

  modport master (
    output req_valid, req_write, req_addr, req_data, req_byte_en, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_addr
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_byte_en, resp_ready,
    output req_ready, resp_valid, resp_data, resp_addr
  );
endinterface

// File: rtl/pipelined_mem_interface_mem_resp_fifo.sv
// First-word-fall-through response FIFO with occupancy count. When empty the
// output keeps showing the most recently popped entry (zero after reset).
module mem_resp_fifo
  import pipelined_mem_interface_pkg::*;
#(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_push,
  input  logic [WIDTH-1:0]          i_push_data,
  input  logic                      i_pop,
  output logic                      o_valid,
  output logic [WIDTH-1:0]          o_data,
  output logic [cnt_w(DEPTH)-1:0]   o_count
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_pop;

  assign w_pop   = i_pop & (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : r_last;
  assign o_count = r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/pipelined_mem_interface.sv
// Pipelined word-RAM front end: byte-enabled writes, credit-limited reads with
// configurable latency, in-order responses with backpressure, state snapshot.
module pipelined_mem_interface
  import pipelined_mem_interface_pkg::*;
#(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20,
  parameter int READ_LATENCY = 2,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_report,
  pipelined_mem_interface_if.slave      bus,
  output logic [cnt_w(QUEUE_DEPTH)-1:0] o_outstanding,
  output report_t                       o_report
);
  localparam int BYTES   = DATA_WIDTH / 8;
  localparam int CW      = cnt_w(QUEUE_DEPTH);
  localparam int WORDS   = 2 ** ADDRESS_BITS;
  localparam int ENTRY_W = ADDRESS_BITS + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] r_ram [WORDS];
  logic [CW-1:0]         r_outstanding;
  logic [31:0]           r_cycle;
  report_t               r_report;

  logic                  w_req_ready;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_pop;
  logic                  w_push;
  logic [ENTRY_W-1:0]    w_push_entry;
  logic [ENTRY_W-1:0]    w_rd_entry;
  logic                  w_fifo_valid;
  logic [ENTRY_W-1:0]    w_fifo_data;
  logic [CW-1:0]         w_fifo_count;

  // Credits cover both in-flight and queued reads, so the FIFO cannot overflow.
  assign w_req_ready = !i_reset && (r_outstanding < CW'(QUEUE_DEPTH));
  assign w_wr_accept = bus.req_valid & w_req_ready & bus.req_write;
  assign w_rd_accept = bus.req_valid & w_req_ready & !bus.req_write;
  assign w_pop       = w_fifo_valid & bus.resp_ready;
  assign w_rd_entry  = {bus.req_addr, r_ram[bus.req_addr]};

  always_ff @(posedge i_clock) begin
    if (w_wr_accept) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.req_byte_en[b]) r_ram[bus.req_addr][8*b +: 8] <= bus.req_data[8*b +: 8];
      end
    end
  end

  // Read stage boundary: RAM word captured at accept, then delayed to the FIFO.
  if (READ_LATENCY == 1) begin : g_direct
    assign w_push       = w_rd_accept;
    assign w_push_entry = w_rd_entry;
  end else begin : g_delay
    logic               r_vld_p   [READ_LATENCY-1];
    logic [ENTRY_W-1:0] r_entry_p [READ_LATENCY-1];

    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        for (int i = 0; i < READ_LATENCY-1; i++) r_vld_p[i] <= 1'b0;
      end else begin
        r_vld_p[0] <= w_rd_accept;
        for (int i = 1; i < READ_LATENCY-1; i++) r_vld_p[i] <= r_vld_p[i-1];
      end
    end

    always_ff @(posedge i_clock) begin
      r_entry_p[0] <= w_rd_entry;
      for (int i = 1; i < READ_LATENCY-1; i++) r_entry_p[i] <= r_entry_p[i-1];
    end

    assign w_push       = r_vld_p[READ_LATENCY-2];
    assign w_push_entry = r_entry_p[READ_LATENCY-2];
  end

  // Response stage boundary: in-order queue feeding the consumer.
  mem_resp_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_resp_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (bus.resp_ready),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_outstanding <= '0;
      r_cycle       <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_rd_accept) - CW'(w_pop);
      r_cycle       <= r_cycle + 32'd1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_report <= '0;
    end else if (i_report) begin
      r_report.cycle       <= r_cycle;
      r_report.core        <= 8'(CORE);
      r_report.req_valid   <= bus.req_valid;
      r_report.req_ready   <= w_req_ready;
      r_report.req_write   <= bus.req_write;
      r_report.resp_valid  <= w_fifo_valid;
      r_report.resp_ready  <= bus.resp_ready;
      r_report.req_addr    <= 32'(bus.req_addr);
      r_report.resp_addr   <= 32'(w_fifo_data[ENTRY_W-1:DATA_WIDTH]);
      r_report.outstanding <= 8'(r_outstanding);
      r_report.fifo_level  <= 8'(w_fifo_count);
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_fifo_valid;
  assign bus.resp_data  = w_fifo_data[DATA_WIDTH-1:0];
  assign bus.resp_addr  = w_fifo_data[ENTRY_W-1:DATA_WIDTH];
  assign o_outstanding  = r_outstanding;
  assign o_report       = r_report;

endmodule

// File: tb/tb_pipelined_mem_interface.sv
// Scoreboard bench for pipelined_mem_interface: a shadow memory predicts read
// data, a queue holds expected responses in acceptance order.
module tb_pipelined_mem_interface;
  import pipelined_mem_interface_pkg::*;

  localparam int DW   = 32;
  localparam int AB   = 8;
  localparam int RL   = 2;
  localparam int QD   = 4;
  localparam int CORE = 3;
  localparam int CW   = cnt_w(QD);

  logic          clk;
  logic          rst;
  logic          report;
  logic [CW-1:0] outstanding;
  report_t       rep;

  logic [DW-1:0]    shadow [2**AB];
  logic [AB+DW-1:0] sb [$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  pipelined_mem_interface_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB)) bus ();

  pipelined_mem_interface #(
    .CORE(CORE), .DATA_WIDTH(DW), .ADDRESS_BITS(AB),
    .READ_LATENCY(RL), .QUEUE_DEPTH(QD)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_report      (report),
    .bus           (bus),
    .o_outstanding (outstanding),
    .o_report      (rep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: credit count, ready, and in-order response contents.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      compared++;
      if (int'(outstanding) != sb.size()) begin
        mismatched++;
        $display("FAIL outstanding: got %0d expected %0d", outstanding, sb.size());
      end
      compared++;
      if (bus.req_ready !== (sb.size() < QD)) begin
        mismatched++;
        $display("FAIL req_ready: got %0b expected %0b", bus.req_ready, sb.size() < QD);
      end
      if (bus.resp_valid && bus.resp_ready) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_resp: got addr %0h data %0h expected none",
                   bus.resp_addr, bus.resp_data);
        end else begin
          logic [AB+DW-1:0] exp;
          exp = sb.pop_front();
          if ({bus.resp_addr, bus.resp_data} !== exp) begin
            mismatched++;
            $display("FAIL resp: got addr %0h data %0h expected addr %0h data %0h",
                     bus.resp_addr, bus.resp_data, exp[AB+DW-1:DW], exp[DW-1:0]);
          end
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        if (bus.req_write) begin
          for (int b = 0; b < DW/8; b++)
            if (bus.req_byte_en[b]) shadow[bus.req_addr][8*b +: 8] = bus.req_data[8*b +: 8];
        end else begin
          sb.push_back({bus.req_addr, shadow[bus.req_addr]});
        end
      end
    end
  end

  task automatic drive_req(input logic wr, input logic [AB-1:0] a, input logic [DW-1:0] d,
                           input logic [DW/8-1:0] be, output int acc_cyc);
    int guard;
    guard = 0;
    acc_cyc = -1;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a;
    bus.req_data = d; bus.req_byte_en = be;
    while (acc_cyc < 0 && guard < 50) begin
      @(negedge clk);
      if (bus.req_ready) acc_cyc = cyc;
      @(posedge clk); #1;
      guard++;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    for (int g = 0; g < 60; g++) begin
      @(negedge clk);
      if (outstanding == 0 && !bus.resp_valid) break;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int c0, c1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    compared++; if (bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL rst_req_ready: got %0b expected 0", bus.req_ready); end
    compared++; if (bus.resp_valid !== 1'b0) begin mismatched++; $display("FAIL rst_resp_valid: got %0b expected 0", bus.resp_valid); end
    compared++; if (bus.resp_data !== '0) begin mismatched++; $display("FAIL rst_resp_data: got %0h expected 0", bus.resp_data); end
    compared++; if (bus.resp_addr !== '0) begin mismatched++; $display("FAIL rst_resp_addr: got %0h expected 0", bus.resp_addr); end
    compared++; if (outstanding !== '0) begin mismatched++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
    @(posedge clk); #1;
    rst = 1'b0;
    report = 1'b1;
    @(negedge clk);
    compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL post_rst_ready: got %0b expected 1", bus.req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    c0 = int'(rep.cycle);
    @(posedge clk); #1;
    @(negedge clk);
    c1 = int'(rep.cycle);
    report = 1'b0;
    compared++; if (c1 - c0 != 1) begin mismatched++; $display("FAIL report_cycle: got step %0d expected 1", c1 - c0); end
    compared++; if (rep.core !== 8'(CORE)) begin mismatched++; $display("FAIL report_core: got %0d expected %0d", rep.core, CORE); end
    @(posedge clk); #1;
  endtask

  task automatic preload();
    int acc;
    bus.resp_ready = 1'b1;
    for (int a = 0; a < 64; a++) drive_req(1'b1, AB'(a), DW'($urandom), 4'hF, acc);
  endtask

  task automatic test_reset_midstream();
    logic saw;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr = AB'(i + 1);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    compared++; if (outstanding !== '0) begin mismatched++; $display("FAIL mid_rst_outstanding: got %0d expected 0", outstanding); end
    compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL mid_rst_ready: got %0b expected 1", bus.req_ready); end
    bus.resp_ready = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.resp_valid) saw = 1'b1;
    end
    compared++; if (saw !== 1'b0) begin mismatched++; $display("FAIL mid_rst_dropped: got resp_valid 1 expected 0"); end
    @(posedge clk); #1;
  endtask

  task automatic read_and_wait(input logic [AB-1:0] a, output logic got,
                               output logic [DW-1:0] data, output int lat);
    int acc;
    got = 1'b0; data = '0; lat = -1;
    bus.resp_ready = 1'b1;
    drive_req(1'b0, a, '0, '0, acc);
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1; data = bus.resp_data; lat = cyc - acc;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int acc, lat;
    logic got;
    logic [DW-1:0] d;
    drive_req(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, acc);
    read_and_wait(8'h10, got, d, lat);
    compared++; if (got !== 1'b1) begin mismatched++; $display("FAIL wr_rd_timeout: got no response expected one"); end
    compared++; if (d !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_rd_data: got %0h expected deadbeef", d); end
    compared++; if (lat != RL) begin mismatched++; $display("FAIL wr_rd_latency: got %0d expected %0d", lat, RL); end
  endtask

  task automatic test_byte_merge();
    int acc, lat;
    logic got;
    logic [DW-1:0] d;
    drive_req(1'b1, 8'h20, 32'h11223344, 4'hF, acc);
    drive_req(1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, acc);
    read_and_wait(8'h20, got, d, lat);
    compared++; if (d !== 32'h11BB33DD) begin mismatched++; $display("FAIL byte_merge: got %0h expected 11bb33dd", d); end
  endtask

  task automatic test_backpressure();
    int accepted, n;
    logic [AB-1:0] got [8];
    drain();
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      bus.req_addr = AB'(8'h30 + i);
      @(negedge clk);
      if (bus.req_ready) accepted++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    compared++; if (accepted != QD) begin mismatched++; $display("FAIL bp_accepted: got %0d expected %0d", accepted, QD); end
    compared++; if (bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL bp_full_ready: got %0b expected 0", bus.req_ready); end
    compared++; if (outstanding !== CW'(QD)) begin mismatched++; $display("FAIL bp_outstanding: got %0d expected %0d", outstanding, QD); end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        compared++; if (bus.req_ready !== 1'b0) begin mismatched++; $display("FAIL bp_pop_cycle_ready: got %0b expected 0", bus.req_ready); end
      end
      if (c == 1) begin
        compared++; if (bus.req_ready !== 1'b1) begin mismatched++; $display("FAIL bp_reraise_ready: got %0b expected 1", bus.req_ready); end
      end
      if (bus.resp_valid && n < 8) begin got[n] = bus.resp_addr; n++; end
      @(posedge clk); #1;
    end
    compared++; if (n != QD) begin mismatched++; $display("FAIL bp_resp_count: got %0d expected %0d", n, QD); end
    for (int i = 0; i < QD; i++) begin
      compared++;
      if (got[i] !== AB'(8'h30 + i)) begin mismatched++; $display("FAIL bp_order: got %0h expected %0h", got[i], 8'h30 + i); end
    end
  endtask

  task automatic test_streaming();
    int n_sent, n_resp, drops, first, last;
    drain();
    bus.resp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = '0;
    n_sent = 0; n_resp = 0; drops = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_valid) begin
        if (!bus.req_ready) drops++;
        else n_sent++;
      end
      if (bus.resp_valid) begin
        if (first < 0) first = c;
        last = c;
        n_resp++;
      end
      @(posedge clk); #1;
      if (n_sent >= 16) bus.req_valid = 1'b0;
      else bus.req_addr = AB'(n_sent);
    end
    compared++; if (n_resp != 16) begin mismatched++; $display("FAIL stream_count: got %0d expected 16", n_resp); end
    compared++; if (drops != 0) begin mismatched++; $display("FAIL stream_ready_drop: got %0d expected 0", drops); end
    compared++; if (last - first != 15) begin mismatched++; $display("FAIL stream_consecutive: got span %0d expected 15", last - first); end
  endtask

  task automatic test_simultaneous();
    drain();
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_write = 1'b0;
    for (int i = 0; i < QD-1; i++) begin
      bus.req_addr = AB'(8'h08 + i);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    for (int g = 0; g < 10; g++) begin
      @(negedge clk);
      if (bus.resp_valid) break;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_addr = 8'h0B; bus.resp_ready = 1'b1;
    @(negedge clk);
    compared++;
    if ((bus.req_ready & bus.resp_valid) !== 1'b1) begin
      mismatched++;
      $display("FAIL simul_both_fire: got ready %0b valid %0b expected 1 1", bus.req_ready, bus.resp_valid);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b0;
    @(negedge clk);
    compared++; if (outstanding !== CW'(QD-1)) begin mismatched++; $display("FAIL simul_outstanding: got %0d expected %0d", outstanding, QD-1); end
    @(posedge clk); #1;
  endtask

  task automatic test_soak();
    drain();
    for (int c = 0; c < 400; c++) begin
      bus.req_valid   = ($urandom_range(0, 9) < 7);
      bus.req_write   = ($urandom_range(0, 3) == 0);
      bus.req_addr    = AB'($urandom_range(0, 63));
      bus.req_data    = DW'($urandom);
      bus.req_byte_en = 4'($urandom);
      bus.resp_ready  = ($urandom_range(0, 3) != 0);
      report          = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end
    report = 1'b0;
    drain();
    compared++; if (sb.size() != 0) begin mismatched++; $display("FAIL soak_leftover: got %0d expected 0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1; report = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_data = '0; bus.req_byte_en = '0; bus.resp_ready = 1'b0;
    for (int i = 0; i < 2**AB; i++) shadow[i] = '0;
    test_reset();
    preload();
    test_reset_midstream();
    test_write_read();
    test_byte_merge();
    test_backpressure();
    test_streaming();
    test_simultaneous();
    test_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
